// File: rtl/inst_cache.sv
`default_nettype none
// ============================================================================
// Module      : inst_cache
// Description : Direct-mapped, read-only instruction cache sitting between
//               the fetch read port and the instruction memory bus. Hits
//               answer one cycle after the request is sampled, one per cycle.
//               Misses block while the line is refilled word 0..N-1, one
//               single-word memory read outstanding at a time. flush
//               invalidates every line.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               flush               - invalidate all lines
//               req_avalid/req_addr - fetch request (byte address)
//               resp_valid/resp_data- fetch response (data 0 when not valid)
//               mem_avalid/mem_addr - memory read request pulse / address
//               mem_valid/mem_data  - memory read return
// Revision    : 1.0 - initial release
// ============================================================================
module inst_cache #(
    parameter int LINES      = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        req_avalid,
    input  logic [31:0] req_addr,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        mem_avalid,
    output logic [31:0] mem_addr,
    input  logic        mem_valid,
    input  logic [31:0] mem_data
);

    localparam int c_WORD_W  = $clog2(LINE_WORDS);
    localparam int c_IDX_W   = $clog2(LINES);
    localparam int c_IDX_LSB = 2 + c_WORD_W;
    localparam int c_TAG_LSB = c_IDX_LSB + c_IDX_W;
    localparam int c_TAG_W   = 32 - c_TAG_LSB;
    localparam int c_LINE_W  = 32 - c_IDX_LSB;   // tag + index
    localparam logic [c_WORD_W-1:0] c_LAST_WORD = c_WORD_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        S_LOOKUP      = 2'd0,
        S_REFILL_REQ  = 2'd1,
        S_REFILL_WAIT = 2'd2,
        S_DRAIN       = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Storage: valid bits in flops, tag/data in synchronously read arrays.
    logic [LINES-1:0]   r_valid;
    logic [c_TAG_W-1:0] r_tag_mem  [LINES];
    logic [31:0]        r_data_mem [LINES*LINE_WORDS];
    logic [c_TAG_W-1:0] r_tag_rd;
    logic [31:0]        r_data_rd;

    // Sampled request (line part only; the word was consumed by the read).
    logic                r_req_vld;
    logic [c_LINE_W-1:0] r_req_line;

    // Refill bookkeeping.
    logic [c_LINE_W-1:0] r_line;
    logic [c_WORD_W-1:0] r_cnt;
    logic                r_drain_pend;

    logic               w_sample;
    logic               w_miss;
    logic               w_abort;
    logic               w_line_hit;
    logic               w_fill_word;
    logic               w_fill_last;
    logic [c_IDX_W-1:0] w_req_idx;
    logic [c_TAG_W-1:0] w_req_tag;
    logic [c_IDX_W-1:0] w_in_idx;
    logic [c_WORD_W-1:0] w_in_word;
    logic [c_IDX_W-1:0] w_fill_idx;
    logic [c_TAG_W-1:0] w_fill_tag;
    logic               w_unused_off;

    assign w_req_idx   = r_req_line[c_IDX_W-1:0];
    assign w_req_tag   = r_req_line[c_LINE_W-1:c_IDX_W];
    assign w_in_idx    = req_addr[c_TAG_LSB-1:c_IDX_LSB];
    assign w_in_word   = req_addr[c_IDX_LSB-1:2];
    assign w_fill_idx  = r_line[c_IDX_W-1:0];
    assign w_fill_tag  = r_line[c_LINE_W-1:c_IDX_W];
    assign w_unused_off = ^req_addr[1:0];

    assign w_line_hit  = r_valid[w_req_idx] && (r_tag_rd == w_req_tag);
    assign w_fill_word = (r_state == S_REFILL_WAIT) && mem_valid;
    assign w_fill_last = w_fill_word && (r_cnt == c_LAST_WORD);
    assign w_abort     = flush && ((r_state == S_REFILL_REQ) || (r_state == S_REFILL_WAIT));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_LOOKUP;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        resp_valid  = 1'b0;
        resp_data   = '0;
        mem_avalid  = 1'b0;
        mem_addr    = '0;
        w_sample    = 1'b0;
        w_miss      = 1'b0;
        case (r_state)
            S_LOOKUP: begin
                // A flush cycle kills the pending answer and samples nothing;
                // the fetch stage re-presents its address afterwards.
                if (!flush) begin
                    if (r_req_vld && !w_line_hit) begin
                        w_miss      = 1'b1;
                        w_state_nxt = S_REFILL_REQ;
                    end else begin
                        resp_valid = r_req_vld;
                        resp_data  = r_req_vld ? r_data_rd : '0;
                        w_sample   = req_avalid;
                    end
                end
            end
            S_REFILL_REQ: begin
                mem_avalid  = 1'b1;
                mem_addr    = {r_line, r_cnt, 2'b00};
                w_state_nxt = flush ? S_DRAIN : S_REFILL_WAIT;
            end
            S_REFILL_WAIT: begin
                if (flush) begin
                    w_state_nxt = S_DRAIN;
                end else if (mem_valid) begin
                    w_state_nxt = (r_cnt == c_LAST_WORD) ? S_LOOKUP : S_REFILL_REQ;
                end
            end
            S_DRAIN: begin
                if (!r_drain_pend || mem_valid) begin
                    w_state_nxt = S_LOOKUP;
                end
            end
            default: begin
                w_state_nxt = S_LOOKUP;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Control registers and valid bits
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid      <= '0;
            r_req_vld    <= 1'b0;
            r_req_line   <= '0;
            r_line       <= '0;
            r_cnt        <= '0;
            r_drain_pend <= 1'b0;
        end else begin
            r_req_vld <= w_sample;
            if (w_sample) begin
                r_req_line <= req_addr[31:c_IDX_LSB];
            end

            // Flush beats a refill completing in the same cycle.
            if (flush) begin
                r_valid <= '0;
            end else if (w_fill_last) begin
                r_valid[w_fill_idx] <= 1'b1;
            end

            if (w_miss) begin
                r_line <= r_req_line;
                r_cnt  <= '0;
            end else if (w_abort) begin
                r_cnt <= '0;
                // A request issued this cycle, or one still in flight,
                // must be swallowed before lookups resume.
                r_drain_pend <= (r_state == S_REFILL_REQ) || !mem_valid;
            end else if (w_fill_word) begin
                r_cnt <= r_cnt + c_WORD_W'(1);
            end

            if ((r_state == S_DRAIN) && mem_valid) begin
                r_drain_pend <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Tag / data arrays (no reset, synchronous read)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_sample) begin
            r_tag_rd  <= r_tag_mem[w_in_idx];
            r_data_rd <= r_data_mem[{w_in_idx, w_in_word}];
        end
        if (w_fill_word) begin
            r_data_mem[{w_fill_idx, r_cnt}] <= mem_data;
        end
        if (w_fill_last && !flush) begin
            r_tag_mem[w_fill_idx] <= w_fill_tag;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inst_cache.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_cache
// Description : Self-checking bench for inst_cache. A memory responder with
//               programmable latency returns addr^0xA5A5_0000; a line-level
//               model of cache contents plus the documented miss/flush timing
//               formulas predict every response and memory request.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_cache;

    localparam int c_LINES = 64;
    localparam int c_LW    = 4;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        req_avalid;
    logic [31:0] req_addr;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        mem_avalid;
    logic [31:0] mem_addr;
    logic        mem_valid;
    logic [31:0] mem_data;

    inst_cache #(
        .LINES      (c_LINES),
        .LINE_WORDS (c_LW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .req_avalid (req_avalid),
        .req_addr   (req_addr),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .mem_avalid (mem_avalid),
        .mem_addr   (mem_addr),
        .mem_valid  (mem_valid),
        .mem_data   (mem_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int lat     = 1;
    int b2b     = 0;
    logic [31:0] mem_log[$];
    logic [31:0] stream_q[$];

    bit          m_valid [c_LINES];
    int unsigned m_tag   [c_LINES];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[31:2], 2'b00} ^ 32'hA5A5_0000;
    endfunction

    function automatic int line_idx(input logic [31:0] a);
        return int'(((a >> 2) / c_LW) % c_LINES);
    endfunction

    function automatic int unsigned line_tag(input logic [31:0] a);
        return a / (c_LINES * c_LW * 4);
    endfunction

    function automatic logic [31:0] line_base(input logic [31:0] a);
        return a - (a % (c_LW * 4));
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        return m_valid[line_idx(a)] && (m_tag[line_idx(a)] == line_tag(a));
    endfunction

    task automatic model_clear();
        for (int i = 0; i < c_LINES; i++) m_valid[i] = 1'b0;
    endtask

    task automatic model_fill(input logic [31:0] a);
        m_valid[line_idx(a)] = 1'b1;
        m_tag[line_idx(a)]   = line_tag(a);
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned t, i, w, o;
        t = $urandom_range(0, 3);
        i = $urandom_range(0, 3);
        w = $urandom_range(0, c_LW - 1);
        o = $urandom_range(0, 3);
        return 32'(((t * c_LINES + i) * c_LW + w) * 4 + o);
    endfunction

    // Memory responder: answers each request after `lat` cycles.
    initial begin
        logic [31:0] a;
        mem_valid = 1'b0;
        mem_data  = '0;
        forever begin
            @(negedge clk);
            if (mem_avalid === 1'b1) begin
                a = mem_addr;
                repeat (lat) @(posedge clk);
                #1;
                mem_valid = 1'b1;
                mem_data  = mem_word(a);
                @(posedge clk);
                #1;
                mem_valid = 1'b0;
                mem_data  = '0;
            end
        end
    end

    // Request monitor: logs addresses, counts back-to-back pulses.
    initial begin
        bit prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_avalid === 1'b1) begin
                mem_log.push_back(mem_addr);
                if (prev) b2b++;
            end
            prev = (mem_avalid === 1'b1);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_line_reqs(input string tag, input logic [31:0] a, input int first_n);
        // Expect first_n words of a partial refill followed by a full refill.
        int total;
        logic [31:0] exp;
        total = first_n + c_LW;
        chk({tag, "_memreq_cnt"}, 32'(mem_log.size()), 32'(total));
        for (int i = 0; i < total && i < mem_log.size(); i++) begin
            exp = line_base(a) + 32'(4 * ((i < first_n) ? i : i - first_n));
            chk({tag, "_memreq_addr"}, mem_log[i], exp);
        end
    endtask

    // Present address a until its response; the request is sampled in cycle 0.
    task automatic fetch(input logic [31:0] a);
        bit hit;
        int exp_c, spur;
        hit   = model_hit(a);
        exp_c = hit ? 1 : 3 + c_LW * (lat + 1);
        spur  = 0;
        mem_log.delete();
        for (int c = 0; c <= exp_c; c++) begin
            req_avalid = (c < exp_c);
            req_addr   = a;
            @(negedge clk);
            if (c == exp_c) begin
                chk("fetch_valid", {31'b0, resp_valid}, 32'd1);
                chk("fetch_data", resp_data, mem_word(a));
            end else if (c > 0 && resp_valid) begin
                spur++;
            end
            next_cycle();
        end
        req_avalid = 1'b0;
        chk("fetch_spurious", 32'(spur), 32'd0);
        if (hit) begin
            chk("hit_memreq_cnt", 32'(mem_log.size()), 32'd0);
        end else begin
            chk_line_reqs("miss", a, 0);
            model_fill(a);
        end
    endtask

    // Present stream_q addresses back to back (all expected hits).
    task automatic run_stream(input bit gaps);
        int n, idx, spur, guard;
        bit pv, v;
        logic [31:0] pa, a;
        n = stream_q.size();
        idx = 0; spur = 0; guard = 0; pv = 1'b0; pa = '0;
        mem_log.delete();
        while ((idx < n || pv) && guard < 8 * n + 8) begin
            v = 1'b0;
            a = $urandom;
            if (idx < n && !(gaps && $urandom_range(0, 3) == 0)) begin
                v = 1'b1;
                a = stream_q[idx];
                idx++;
            end
            req_avalid = v;
            req_addr   = a;
            @(negedge clk);
            if (pv) begin
                chk("stream_valid", {31'b0, resp_valid}, 32'd1);
                chk("stream_data", resp_data, mem_word(pa));
            end else if (resp_valid) begin
                spur++;
            end
            pv = v;
            pa = a;
            next_cycle();
            guard++;
        end
        req_avalid = 1'b0;
        chk("stream_done", 32'(idx) + {31'b0, pv}, 32'(n));
        chk("stream_spurious", 32'(spur), 32'd0);
        chk("stream_memreq_cnt", 32'(mem_log.size()), 32'd0);
    endtask

    task automatic flush_lookup(input logic [31:0] a);
        req_avalid = model_hit(a);
        req_addr   = a;
        @(negedge clk);
        next_cycle();
        flush      = 1'b1;
        req_avalid = 1'b1;
        @(negedge clk);
        chk("flush_kill", {31'b0, resp_valid}, 32'd0);
        next_cycle();
        flush      = 1'b0;
        req_avalid = 1'b0;
        @(negedge clk);
        chk("flush_nosample", {31'b0, resp_valid}, 32'd0);
        next_cycle();
        model_clear();
        fetch(a);
    endtask

    // Flush during word k of a refill, j cycles after its memory request.
    task automatic flush_refill(input logic [31:0] a, input int k, input int j);
        int fc, m, t, tt, spur;
        fc = 2 + k * (lat + 1) + j;
        m  = 2 + k * (lat + 1) + lat;
        t  = (j == lat) ? fc + 2 : m + 1;
        tt = t + 3 + c_LW * (lat + 1);
        spur = 0;
        mem_log.delete();
        for (int c = 0; c <= tt; c++) begin
            req_avalid = (c < tt);
            req_addr   = a;
            flush      = (c == fc);
            @(negedge clk);
            if (c == tt) begin
                chk("fref_valid", {31'b0, resp_valid}, 32'd1);
                chk("fref_data", resp_data, mem_word(a));
            end else if (c > 0 && resp_valid) begin
                spur++;
            end
            next_cycle();
        end
        flush      = 1'b0;
        req_avalid = 1'b0;
        chk("fref_spurious", 32'(spur), 32'd0);
        chk_line_reqs("fref", a, k + 1);
        model_clear();
        model_fill(a);
    endtask

    // Reset during word k of a refill, j cycles after its memory request.
    task automatic reset_refill(input logic [31:0] a, input int k, input int j);
        int rc, spur;
        rc = 2 + k * (lat + 1) + j;
        spur = 0;
        mem_log.delete();
        for (int c = 0; c <= rc; c++) begin
            req_avalid = 1'b1;
            req_addr   = a;
            rst        = (c == rc);
            @(negedge clk);
            if (c > 0 && resp_valid) spur++;
            next_cycle();
        end
        rst        = 1'b0;
        req_avalid = 1'b0;
        @(negedge clk);
        chk("rref_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rref_resp_data", resp_data, 32'd0);
        chk("rref_mem_avalid", {31'b0, mem_avalid}, 32'd0);
        chk("rref_mem_addr", mem_addr, 32'd0);
        next_cycle();
        for (int c = 0; c < lat + 2; c++) begin
            @(negedge clk);
            if (resp_valid) spur++;
            next_cycle();
        end
        chk("rref_spurious", 32'(spur), 32'd0);
        chk("rref_memreq_cnt", 32'(mem_log.size()), 32'(k + 1));
        model_clear();
        fetch(a);
    endtask

    function automatic logic [31:0] force_miss(input logic [31:0] a);
        logic [31:0] r;
        r = a;
        for (int g = 0; g < 8 && model_hit(r); g++) r = r + 32'(4 * c_LINES * c_LW * 4);
        return r;
    endfunction

    initial begin
        int sel, k, j;
        logic [31:0] a;
        int unsigned hit_idx[$];
        rst = 1'b1; flush = 1'b0; req_avalid = 1'b0; req_addr = '0;
        model_clear();
        repeat (3) next_cycle();
        @(negedge clk);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_mem_avalid", {31'b0, mem_avalid}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        next_cycle();
        rst = 1'b0;
        next_cycle();

        // Directed scenarios, memory latency 1.
        lat = 1;
        fetch(32'h0000_0100);
        stream_q = '{32'h100, 32'h104, 32'h108, 32'h10C};
        run_stream(1'b0);
        fetch(32'h0000_0200);
        stream_q = '{32'h100, 32'h104, 32'h200, 32'h204, 32'h108};
        run_stream(1'b0);
        fetch(32'h100 + 32'(c_LINES * c_LW * 4));
        fetch(32'h0000_0100);
        flush_lookup(32'h0000_0100);
        flush_refill(32'h0000_0300, 1, 1);
        lat = 2;
        flush_refill(32'h0000_0340, 1, 1);
        reset_refill(32'h0000_0380, 1, 1);
        lat = 1;
        reset_refill(32'h0000_03C0, 2, 1);

        // Randomized operations.
        for (int op = 0; op < 40; op++) begin
            lat = $urandom_range(1, 3);
            sel = $urandom_range(0, 9);
            a   = rand_addr();
            if (sel <= 3) begin
                fetch(a);
            end else if (sel <= 5) begin
                hit_idx.delete();
                for (int i = 0; i < c_LINES; i++) if (m_valid[i]) hit_idx.push_back(i);
                if (hit_idx.size() == 0) begin
                    fetch(a);
                end else begin
                    stream_q.delete();
                    for (int s = 0; s < $urandom_range(1, 8); s++) begin
                        int unsigned li;
                        li = hit_idx[$urandom_range(0, hit_idx.size() - 1)];
                        stream_q.push_back(32'(((m_tag[li] * c_LINES + li) * c_LW
                                           + $urandom_range(0, c_LW - 1)) * 4 + $urandom_range(0, 3)));
                    end
                    run_stream(1'b1);
                end
            end else if (sel == 6) begin
                flush_lookup(a);
            end else begin
                a = force_miss(a);
                k = $urandom_range(0, c_LW - 1);
                if (sel == 9) begin
                    j = (lat >= 2 && $urandom_range(0, 1) == 1) ? lat - 1 : lat;
                    reset_refill(a, k, j);
                end else begin
                    j = $urandom_range(0, lat);
                    flush_refill(a, k, j);
                end
            end
        end

        chk("mem_avalid_b2b", 32'(b2b), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/inst_cache.md
# inst_cache

Direct-mapped, read-only instruction cache between the fetch stage's instruction read port and the instruction memory bus. It returns hits with one-cycle latency at one instruction per cycle. Misses are serviced by a blocking line refill of consecutive single-word memory reads. A flush input invalidates the whole cache so that instruction-stream changes become visible.

## Interface
Parameters:
- LINES, 64: number of cache lines; power of two, ≥2.
- LINE_WORDS, 4: 32-bit words per line; power of two, ≥2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  invalidate all lines (fence.i).
- req_avalid  in  1  fetch request valid (ReadIF avalid).
- req_addr  in  32  fetch byte address (ReadIF addr); bits [1:0] ignored.
- resp_valid  out  1  response valid (ReadIF valid); single-cycle pulse.
- resp_data  out  32  instruction word (ReadIF data); 0 whenever resp_valid=0.
- mem_avalid  out  1  memory read request pulse.
- mem_addr  out  32  word-aligned memory byte address.
- mem_valid  in  1  memory read data valid.
- mem_data  in  32  memory read data.

## Operation
- Address split: offset = addr[1:0], word = next log2(LINE_WORDS) bits, index = next log2(LINES) bits, tag = the remaining upper bits.
- Storage: valid[LINES], tag[LINES], data[LINES*LINE_WORDS]. Tag and data arrays are read synchronously (BRAM-inferable). Valid bits live in flops.
- FSM states: LOOKUP, REFILL_REQ, REFILL_WAIT, DRAIN.
- LOOKUP:
  - A request is sampled when req_avalid=1; the address is held in req_q.
  - In the following cycle, if valid[idx] and tag matches: resp_valid=1 and resp_data = the addressed word. Stay in LOOKUP and sample the next request in the same cycle.
  - On a tag mismatch or invalid line: resp_valid=0, the next state is REFILL_REQ, and the line base is latched from req_q.
- REFILL_REQ:
  - mem_avalid=1 for exactly one cycle; mem_addr = line base + 4*cnt.
  - The next state is REFILL_WAIT.
- REFILL_WAIT:
  - On mem_valid: write mem_data to data[idx, cnt].
  - If cnt = LINE_WORDS-1: write the tag, set valid[idx]=1, clear cnt, and go to LOOKUP.
  - Otherwise: cnt+1 and go to REFILL_REQ.
- Refill is strictly word 0 to LINE_WORDS-1, with one outstanding memory request at a time.
- Requests are ignored (not sampled) outside LOOKUP. The fetch stage keeps presenting its address, which is resampled on return to LOOKUP. No response is ever produced for the missing request itself; the re-presented request hits.
- The fetch side may change req_addr at any time (redirect). Only the address sampled on the previous edge is answered. Stale lookups are never replayed.
- Flush:
  - In LOOKUP, flush clears all valid bits on the edge. The response in the flush cycle is forced to resp_valid=0, and no request is sampled that cycle.
  - In REFILL_REQ or REFILL_WAIT, flush clears all valid bits and moves to DRAIN. DRAIN waits for the outstanding mem_valid (if a request was issued), then returns to LOOKUP without setting valid.
  - In DRAIN, flush is absorbed with no further effect.
- Simultaneous flush and refill completion: flush wins and the line stays invalid.
- mem_valid outside REFILL_WAIT/DRAIN is ignored.

## Timing
- Reset values: resp_valid=0, resp_data=0, mem_avalid=0, mem_addr=0, all valid bits 0, state LOOKUP, cnt=0, req_q invalid. Reset mid-refill abandons the refill immediately; a late mem_valid is ignored.
- Hit latency: request sampled at edge N, resp_valid high in cycle N+1. Back-to-back hits sustain 1 response per cycle.
- Miss:
  - Miss detected in cycle N+1; first mem_avalid in cycle N+2.
  - With memory latency L (mem_valid L≥1 cycles after mem_avalid), each word takes L+1 cycles.
  - State is LOOKUP again in cycle N+2+LINE_WORDS*(L+1).
  - The re-presented request is sampled there, so resp_valid arrives one cycle later.
  - For L=1 and LINE_WORDS=4: 8 refill cycles; first miss request sampled at edge 0, response in cycle 11.
- mem_avalid is never high in two consecutive cycles.
- resp_data is combinational from the array output and the hit compare; there are no stalls on the response side.

## Test plan
- Cold miss: after reset, request 0x0000_0100 with memory returning addr^0xA5A5_0000 (L=1). Required: mem_addr sequence 0x100, 0x104, 0x108, 0x10C; then resp_valid with 0xA5A5_0100 in cycle 11.
- Hit streaming: after filling line 0x100, requests 0x100, 0x104, 0x108, 0x10C on consecutive cycles. Required: 4 consecutive resp_valid cycles, data matching, and no mem_avalid.
- Conflict eviction: fill 0x100, then request 0x100 + LINES*LINE_WORDS*4 (same index). Required: refill of the new tag; a re-request of 0x100 then misses again.
- Redirect: during a hit stream, change req_addr to a filled address 0x200. Required: the next response is data[0x200]; no response for the abandoned address.
- Flush mid-refill: assert flush while in REFILL_WAIT for word 1. Required: the outstanding mem_valid is consumed, the state returns to LOOKUP, and the re-request misses (full refill repeats). Flush while in LOOKUP makes a previously hit line miss.
- Reset mid-refill: assert rst in REFILL_WAIT with mem_valid arriving in the same or next cycle. Required: all outputs at reset values, and a subsequent request to the same line misses.
